// File: rtl/noc_local_ni.sv
// rtl/noc_local_ni.sv - Local-port network interface between a PageRank compute element and its router.
module noc_local_ni #(
    parameter logic [1:0] LOCAL_IP  = 2'b00,
    parameter int         TX_DEPTH  = 4,
    parameter int         RX_DEPTH  = 8,
    parameter int         AF_MARGIN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [1:0]  tx_dst,
    input  logic [12:0] tx_payload,
    input  logic        inj_full,
    input  logic        inj_almost_full,
    output logic [15:0] inj_data,
    output logic        inj_write,
    input  logic [15:0] ej_data,
    input  logic        ej_write,
    output logic        ej_full,
    output logic        ej_almost_full,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [12:0] rx_payload,
    output logic        rx_dst_err,
    output logic        rx_overflow,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);
    localparam int TW = $clog2(TX_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);
    localparam logic [TW:0] TX_FULL = (TW+1)'(TX_DEPTH);
    localparam logic [TW:0] TX_ONE  = (TW+1)'(1);
    localparam logic [RW:0] RX_FULL = (RW+1)'(RX_DEPTH);
    localparam logic [RW:0] RX_AF   = (RW+1)'(RX_DEPTH - AF_MARGIN);
    localparam logic [RW:0] RX_ONE  = (RW+1)'(1);

    // Injection queue
    logic [15:0]   tx_mem [TX_DEPTH];
    logic [TW-1:0] tx_wptr, tx_rptr;
    logic [TW:0]   tx_occ, tx_occ_next;
    logic          inj_ok;
    logic          tx_push, tx_pop;

    assign tx_push = tx_valid & tx_ready;
    assign tx_pop  = inj_ok & (tx_occ != '0);

    always_comb begin
        tx_occ_next = tx_occ;
        case ({tx_push, tx_pop})
            2'b10:   tx_occ_next = tx_occ + TX_ONE;
            2'b01:   tx_occ_next = tx_occ - TX_ONE;
            default: tx_occ_next = tx_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= {tx_payload, tx_dst, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            tx_occ    <= '0;
            tx_ready  <= 1'b0;
            inj_ok    <= 1'b0;
            inj_write <= 1'b0;
            inj_data  <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TW'(1);
            if (tx_pop) begin
                tx_rptr  <= tx_rptr + TW'(1);
                inj_data <= tx_mem[tx_rptr];
            end
            inj_write <= tx_pop;
            tx_occ    <= tx_occ_next;
            tx_ready  <= (tx_occ_next != TX_FULL);
            // Same credit rule the router applies to its own downstream writes
            inj_ok    <= ~((inj_almost_full & inj_write) | inj_full);
            tx_count  <= tx_count + {15'd0, inj_write};
        end
    end

    // Receive FIFO, first-word-fall-through
    logic [12:0]   rx_mem [RX_DEPTH];
    logic [RW-1:0] rx_wptr, rx_rptr;
    logic [RW:0]   rx_occ, rx_occ_next;
    logic          rx_flit, rx_fifo_full, rx_push, rx_pop;

    assign rx_flit      = ej_write & ej_data[0];
    assign rx_fifo_full = (rx_occ == RX_FULL);
    assign rx_pop       = rx_valid & rx_ready;
    assign rx_push      = rx_flit & (~rx_fifo_full | rx_pop);
    assign rx_valid     = (rx_occ != '0);
    assign rx_payload   = rx_valid ? rx_mem[rx_rptr] : '0;

    always_comb begin
        rx_occ_next = rx_occ;
        case ({rx_push, rx_pop})
            2'b10:   rx_occ_next = rx_occ + RX_ONE;
            2'b01:   rx_occ_next = rx_occ - RX_ONE;
            default: rx_occ_next = rx_occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= ej_data[15:3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr        <= '0;
            rx_rptr        <= '0;
            rx_occ         <= '0;
            ej_full        <= 1'b0;
            ej_almost_full <= 1'b0;
            rx_dst_err     <= 1'b0;
            rx_overflow    <= 1'b0;
            rx_count       <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RW'(1);
            rx_occ         <= rx_occ_next;
            ej_full        <= (rx_occ_next == RX_FULL);
            ej_almost_full <= (rx_occ_next >= RX_AF);
            if (rx_push && ej_data[2:1] != LOCAL_IP) rx_dst_err <= 1'b1;
            if (rx_flit && !rx_push) rx_overflow <= 1'b1;
            rx_count <= rx_count + {15'd0, rx_push};
        end
    end
endmodule
